rom_loader: RTL and testbench

ROM_LOADER -- requirements
Module: rom_loader

---
 rtl/rom_loader.sv | 140 ++++++++++++++
 tb/tb_rom_loader.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_loader.sv
// rom_loader: byte-stream program loader into a 16-bit instruction ROM; holds the CPU in reset until loaded.
// Optional checksum stage enabled by defining ROM_CHECKSUM_EN. Rev 1.0
`default_nettype none

module rom_loader #(
    parameter int ADDR_W = 15
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic [15:0]       inst_o,
    output logic              cpu_reset_o,
    input  logic              load_start_i,
    input  logic [7:0]        byte_i,
    input  logic              byte_valid_i,
    output logic              byte_ready_o,
    output logic              busy_o,
    output logic              err_o,
    output logic [15:0]       word_cnt_o
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_LEN_HI  = 4'd1,
        S_LEN_LO  = 4'd2,
        S_DATA_HI = 4'd3,
        S_DATA_LO = 4'd4,
`ifdef ROM_CHECKSUM_EN
        S_CSUM_HI = 4'd5,
        S_CSUM_LO = 4'd6,
        S_ERROR   = 4'd8,
`endif
        S_RUN     = 4'd7
    } state_t;

    state_t      r_state;
    logic [15:0] r_len;
    logic [15:0] r_cnt;
    logic [7:0]  r_hi;
    logic [15:0] mem [0:(1<<ADDR_W)-1];

    logic        w_xfer;
    logic        w_wr;
    logic [15:0] w_word;
    logic [15:0] w_cnt_nxt;
    state_t      w_post;

`ifdef ROM_CHECKSUM_EN
    logic [15:0] r_csum;
    logic        r_err;
    assign w_post = S_CSUM_HI;
    assign err_o  = r_err;
`else
    assign w_post = S_RUN;
    assign err_o  = 1'b0;
`endif

    assign byte_ready_o = (r_state != S_IDLE) && (r_state != S_RUN)
`ifdef ROM_CHECKSUM_EN
                          && (r_state != S_ERROR)
`endif
                          ;
    assign busy_o      = byte_ready_o;
    assign cpu_reset_o = (r_state != S_RUN);
    assign word_cnt_o  = r_cnt;
    assign inst_o      = (r_state == S_RUN) ? mem[pc_i] : 16'h0000;

    assign w_xfer    = byte_valid_i & byte_ready_o;
    assign w_word    = {r_hi, byte_i};
    assign w_cnt_nxt = r_cnt + 16'd1;
    // A restart discards any byte offered in the same cycle, including a data write.
    assign w_wr      = (r_state == S_DATA_LO) && w_xfer && !load_start_i;

    // ROM storage has no reset so a loaded or partial image survives reset_n_i.
    always_ff @(posedge clk_i) begin
        if (w_wr) begin
            mem[r_cnt[ADDR_W-1:0]] <= w_word;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= S_IDLE;
            r_len   <= 16'd0;
            r_cnt   <= 16'd0;
            r_hi    <= 8'd0;
`ifdef ROM_CHECKSUM_EN
            r_csum  <= 16'd0;
            r_err   <= 1'b0;
`endif
        end else if (load_start_i) begin
            r_state <= S_LEN_HI;
            r_cnt   <= 16'd0;
`ifdef ROM_CHECKSUM_EN
            r_csum  <= 16'd0;
            r_err   <= 1'b0;
`endif
        end else if (w_xfer) begin
            case (r_state)
                S_LEN_HI: begin
                    r_len[15:8] <= byte_i;
                    r_state     <= S_LEN_LO;
                end
                S_LEN_LO: begin
                    r_len[7:0] <= byte_i;
                    r_state    <= ({r_len[15:8], byte_i} == 16'd0) ? w_post : S_DATA_HI;
                end
                S_DATA_HI: begin
                    r_hi    <= byte_i;
                    r_state <= S_DATA_LO;
                end
                S_DATA_LO: begin
                    r_cnt   <= w_cnt_nxt;
`ifdef ROM_CHECKSUM_EN
                    r_csum  <= r_csum + w_word;
`endif
                    r_state <= (w_cnt_nxt == r_len) ? w_post : S_DATA_HI;
                end
`ifdef ROM_CHECKSUM_EN
                S_CSUM_HI: begin
                    r_hi    <= byte_i;
                    r_state <= S_CSUM_LO;
                end
                S_CSUM_LO: begin
                    if (w_word == r_csum) begin
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_ERROR;
                        r_err   <= 1'b1;
                    end
                end
`endif
                default: r_state <= r_state;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rom_loader.sv
// tb_rom_loader: randomized self-checking bench for rom_loader against an array/queue reference model.
// Rev 1.0
`default_nettype none

module tb_rom_loader;

    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset_n_i;
    logic [AW-1:0] pc_i;
    logic [15:0]   inst_o;
    logic          cpu_reset_o;
    logic          load_start_i;
    logic [7:0]    byte_i;
    logic          byte_valid_i;
    logic          byte_ready_o;
    logic          busy_o;
    logic          err_o;
    logic [15:0]   word_cnt_o;

    always #5 clk = ~clk;

    rom_loader #(.ADDR_W(AW)) dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n_i),
        .pc_i         (pc_i),
        .inst_o       (inst_o),
        .cpu_reset_o  (cpu_reset_o),
        .load_start_i (load_start_i),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .byte_ready_o (byte_ready_o),
        .busy_o       (busy_o),
        .err_o        (err_o),
        .word_cnt_o   (word_cnt_o)
    );

    logic [15:0] ref_mem [DEPTH];
    bit          ref_ok  [DEPTH];
    logic [7:0]  stream [$];
    logic [15:0] wq [$];
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic start_load();
        @(negedge clk);
        load_start_i = 1'b1;
        @(posedge clk);
        #1 load_start_i = 1'b0;
    endtask

    // mode 0: always valid, 1: alternate valid, 2: random valid
    task automatic send_stream(input int mode);
        int idx = 0;
        int budget = 0;
        bit ph = 1'b1;
        bit v, acc;
        while (idx < stream.size() && budget < 4000) begin
            @(negedge clk);
            case (mode)
                0:       v = 1'b1;
                1:       v = ph;
                default: v = 1'($urandom_range(0, 1));
            endcase
            ph = ~ph;
            byte_valid_i = v;
            byte_i       = stream[idx];
            acc          = v && byte_ready_o;
            @(posedge clk);
            if (acc) idx++;
            budget++;
        end
        @(negedge clk);
        byte_valid_i = 1'b0;
        chk("stream_done", idx, stream.size());
    endtask

    // Build byte stream from wq; optionally corrupt the checksum; update reference ROM.
    task automatic build(input bit bad_csum, input bit partial);
        logic [15:0] n, s;
        n = 16'(wq.size());
        s = 16'd0;
        stream.delete();
        stream.push_back(n[15:8]);
        stream.push_back(n[7:0]);
        foreach (wq[i]) begin
            stream.push_back(wq[i][15:8]);
            stream.push_back(wq[i][7:0]);
            s = s + wq[i];
            ref_mem[i % DEPTH] = wq[i];
            ref_ok[i % DEPTH]  = 1'b1;
        end
        if (bad_csum) s = s - 16'd1;
`ifdef ROM_CHECKSUM_EN
        stream.push_back(s[15:8]);
        stream.push_back(s[7:0]);
`endif
        if (partial) begin
            // keep length + first word + high byte of second word only
            while (stream.size() > 5) void'(stream.pop_back());
            for (int i = 1; i < wq.size(); i++) ref_ok[i % DEPTH] = ref_ok[i % DEPTH];
        end
    endtask

    task automatic check_rom(input string tag);
        for (int a = 0; a < DEPTH; a++) begin
            if (ref_ok[a]) begin
                pc_i = AW'(a);
                #1 chk(tag, inst_o, ref_mem[a]);
            end
        end
    endtask

    task automatic check_run(input int n, input string tag);
        @(negedge clk);
        chk({tag, "_cpu_reset"}, cpu_reset_o, 1'b0);
        chk({tag, "_busy"}, busy_o, 1'b0);
        chk({tag, "_ready"}, byte_ready_o, 1'b0);
        chk({tag, "_err"}, err_o, 1'b0);
        chk({tag, "_cnt"}, word_cnt_o, 32'(n));
        check_rom({tag, "_rom"});
    endtask

    initial begin
        reset_n_i    = 1'b0;
        pc_i         = '0;
        load_start_i = 1'b0;
        byte_i       = 8'h00;
        byte_valid_i = 1'b0;
        foreach (ref_ok[i]) ref_ok[i] = 1'b0;
        #12;
        chk("rst_cpu_reset", cpu_reset_o, 1'b1);
        chk("rst_ready", byte_ready_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_err", err_o, 1'b0);
        chk("rst_cnt", word_cnt_o, 16'd0);
        chk("rst_inst", inst_o, 16'h0000);
        @(negedge clk);
        reset_n_i = 1'b1;

        // Reference load, continuous then alternating valid
        for (int m = 0; m < 2; m++) begin
            wq = '{16'h1234, 16'hABCD};
            build(1'b0, 1'b0);
            start_load();
            chk("load_busy", busy_o, 1'b1);
            chk("load_cpu_reset", cpu_reset_o, 1'b1);
            send_stream(m);
            check_run(2, "ref");
            pc_i = AW'(1);
            #1 chk("ref_pc1", inst_o, 16'hABCD);
        end

        // Zero-length load
        wq.delete();
        build(1'b0, 1'b0);
        start_load();
        send_stream(0);
        check_run(0, "zero");

        // Random loads, some longer than the ROM depth to exercise wrap
        for (int t = 0; t < 6; t++) begin
            int n;
            n = $urandom_range(1, DEPTH + 6);
            wq.delete();
            for (int i = 0; i < n; i++) wq.push_back(16'($urandom));
            if (wq[0] == 16'h1234) wq[0] = 16'h4321;
            build(1'b0, 1'b0);
            start_load();
            send_stream(2);
            check_run(n, "rand");
        end

`ifdef ROM_CHECKSUM_EN
        // Checksum mismatch goes to ERROR; words already written stay
        wq = '{16'h1234, 16'hABCD};
        build(1'b1, 1'b0);
        start_load();
        send_stream(0);
        @(negedge clk);
        chk("bad_err", err_o, 1'b1);
        chk("bad_cpu_reset", cpu_reset_o, 1'b1);
        chk("bad_busy", busy_o, 1'b0);
        pc_i = AW'(1);
        #1 chk("bad_inst", inst_o, 16'h0000);
        start_load();
        chk("restart_err", err_o, 1'b0);
        chk("restart_cnt", word_cnt_o, 16'd0);
        wq = '{16'hAAAA};
        build(1'b0, 1'b0);
        send_stream(2);
        check_run(1, "recover");
        // force ROM[0] away from 1234 before the reset test
`endif

        // Reset after third data byte: ROM[0]=1234 written, load aborted
        wq = '{16'h1234, 16'hABCD};
        build(1'b0, 1'b1);
        ref_ok[1] = 1'b0;
        start_load();
        send_stream(0);
        #2 reset_n_i = 1'b0;
        #1;
        chk("arst_cpu_reset", cpu_reset_o, 1'b1);
        chk("arst_ready", byte_ready_o, 1'b0);
        chk("arst_busy", busy_o, 1'b0);
        chk("arst_err", err_o, 1'b0);
        chk("arst_cnt", word_cnt_o, 16'd0);
        @(negedge clk);
        reset_n_i = 1'b1;
        wq.delete();
        build(1'b0, 1'b0);
        start_load();
        send_stream(0);
        check_run(0, "retain");
        pc_i = AW'(0);
        #1 chk("retain_rom0", inst_o, 16'h1234);

        // Restart from RUN
        @(negedge clk);
        load_start_i = 1'b1;
        #1 chk("run_pre_start", cpu_reset_o, 1'b0);
        @(posedge clk);
        #1 load_start_i = 1'b0;
        chk("run_restart_cpu_reset", cpu_reset_o, 1'b1);
        chk("run_restart_busy", busy_o, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
